// File: rtl/veer_trace_pkg.sv
// veer_trace_pkg
// Shared types and helpers for the VeeR EH1 trace capture block.
//   trace_rec_t : one retired-lane record as presented to the trace sink
//   REC_W       : packed width of trace_rec_t
//   LANES       : retirement lanes per trace bundle
//   lane_count  : number of set lanes in a 2-bit valid vector
package veer_trace_pkg;

    localparam int REC_W = 103;
    localparam int LANES = 2;

    typedef struct packed {
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
        logic [31:0] tval;
        logic [31:0] addr;
        logic [31:0] insn;
    } trace_rec_t;

    function automatic logic [1:0] lane_count(input logic [1:0] valid);
        return {1'b0, valid[0]} + {1'b0, valid[1]};
    endfunction

endpackage

// File: rtl/veer_trace_capture_if.sv
// veer_trace_capture_if
// Valid/ready record stream from the capture block to a trace sink.
//   out_valid : record available (driven by master)
//   out_ready : sink accepts the record (driven by slave)
//   out_data  : packed trace_rec_t (driven by master)
import veer_trace_pkg::*;

interface veer_trace_capture_if;
    logic             out_valid;
    logic             out_ready;
    logic [REC_W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/trace_fifo_2w1r.sv
// trace_fifo_2w1r
// FIFO with two in-order write ports and one registered read port.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : empties the FIFO, overrides writes and pop
//   wr_en0/wr_en1     : write enables; wr_en1 only together with wr_en0
//   wr_data0/wr_data1 : records, wr_data0 is older
//   rd_valid/rd_ready : output handshake
//   rd_data           : head record, held in a register
//   level             : total occupancy including the output register
module trace_fifo_2w1r #(
    parameter int  DEPTH = 64,
    parameter type rec_t = logic [102:0],
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en0,
    input  logic          wr_en1,
    input  rec_t          wr_data0,
    input  rec_t          wr_data1,
    output logic          rd_valid,
    input  logic          rd_ready,
    output rec_t          rd_data,
    output logic [PW-1:0] level
);

    // The output register is the FIFO head; mem holds everything behind it.
    rec_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    rec_t          dout_q;
    logic          dout_vld_q;

    logic          pop, refill, mem_empty;
    logic          load_mem, load_in;
    logic          mem_we0, mem_we1;
    rec_t          mem_d0, mem_d1;
    logic [AW-1:0] idx1;

    assign pop       = dout_vld_q && rd_ready;
    assign refill    = !dout_vld_q || pop;
    assign mem_empty = (wr_ptr == rd_ptr);
    assign idx1      = wr_ptr[AW-1:0] + AW'(1);

    always_comb begin
        load_mem = 1'b0;
        load_in  = 1'b0;
        mem_we0  = wr_en0;
        mem_we1  = wr_en1;
        mem_d0   = wr_data0;
        mem_d1   = wr_data1;
        if (refill) begin
            if (!mem_empty) begin
                load_mem = 1'b1;
            end else if (wr_en0) begin
                // Empty behind the head: the older record bypasses mem.
                load_in = 1'b1;
                mem_we0 = wr_en1;
                mem_we1 = 1'b0;
                mem_d0  = wr_data1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we0) mem[wr_ptr[AW-1:0]] <= mem_d0;
        if (mem_we1) mem[idx1]           <= mem_d1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(mem_we0) + PW'(mem_we1);
            if (load_mem) begin
                dout_q     <= mem[rd_ptr[AW-1:0]];
                dout_vld_q <= 1'b1;
                rd_ptr     <= rd_ptr + PW'(1);
            end else if (load_in) begin
                dout_q     <= wr_data0;
                dout_vld_q <= 1'b1;
            end else if (pop) begin
                dout_vld_q <= 1'b0;
            end
        end
    end

    assign rd_valid = dout_vld_q;
    assign rd_data  = dout_q;
    assign level    = (wr_ptr - rd_ptr) + PW'(dout_vld_q);

endmodule

// File: rtl/veer_trace_capture.sv
// veer_trace_capture
// Splits VeeR EH1 trace bundles into per-lane records, buffers them and
// streams them to a trace sink; counts records lost to overflow.
//   clk, rst               : clock, synchronous active-high reset
//   capture_en             : gate for all trace input
//   flush / clr_stats      : empty the FIFO / zero drop statistics
//   trace_rv_i_*_ip        : retirement bundle from the core
//   sink                   : record stream (master side)
//   level                  : FIFO occupancy 0..DEPTH
//   drop_cnt / overflow    : saturating drop count / sticky drop flag
module veer_trace_capture
    import veer_trace_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                capture_en,
    input  logic                flush,
    input  logic                clr_stats,
    input  logic [63:0]         trace_rv_i_insn_ip,
    input  logic [63:0]         trace_rv_i_address_ip,
    input  logic [2:0]          trace_rv_i_valid_ip,
    input  logic [2:0]          trace_rv_i_exception_ip,
    input  logic [4:0]          trace_rv_i_ecause_ip,
    input  logic [2:0]          trace_rv_i_interrupt_ip,
    input  logic [31:0]         trace_rv_i_tval_ip,
    veer_trace_capture_if.master sink,
    output logic [LW-1:0]       level,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic                overflow
);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic       unused_bits;
    assign unused_bits = ^{trace_rv_i_valid_ip[2], trace_rv_i_exception_ip[2],
                           trace_rv_i_interrupt_ip[2]};

    trace_rec_t rec0, rec1, wr_data0;
    logic [1:0] lane_v, n;
    logic       admit, drop, wr_en0, wr_en1;
    logic       fifo_valid;
    trace_rec_t fifo_data;

    always_comb begin
        rec0 = '{exc: trace_rv_i_exception_ip[0], intr: trace_rv_i_interrupt_ip[0],
                 ecause: trace_rv_i_ecause_ip, tval: trace_rv_i_tval_ip,
                 addr: trace_rv_i_address_ip[31:0], insn: trace_rv_i_insn_ip[31:0]};
        rec1 = '{exc: trace_rv_i_exception_ip[1], intr: trace_rv_i_interrupt_ip[1],
                 ecause: trace_rv_i_ecause_ip, tval: trace_rv_i_tval_ip,
                 addr: trace_rv_i_address_ip[63:32], insn: trace_rv_i_insn_ip[63:32]};
    end

    // Flush-cycle input is discarded outright, so it never counts as a drop.
    assign lane_v = (capture_en && !flush) ? trace_rv_i_valid_ip[1:0] : 2'b00;
    assign n      = lane_count(lane_v);

    // Free space uses level before this cycle's pop; admission is all-or-none.
    assign admit  = {{(LW-2){1'b0}}, n} <= (DEPTH_L - level);
    assign drop   = (n != 2'd0) && !admit;
    assign wr_en0 = (n != 2'd0) && admit;
    assign wr_en1 = (n == 2'd2) && admit;

    // Compact lanes so the older valid record always lands on port 0.
    assign wr_data0 = lane_v[0] ? rec0 : rec1;

    trace_fifo_2w1r #(
        .DEPTH (DEPTH),
        .rec_t (trace_rec_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_en0   (wr_en0),
        .wr_en1   (wr_en1),
        .wr_data0 (wr_data0),
        .wr_data1 (rec1),
        .rd_valid (fifo_valid),
        .rd_ready (sink.out_ready),
        .rd_data  (fifo_data),
        .level    (level)
    );

    assign sink.out_valid = fifo_valid;
    assign sink.out_data  = fifo_data;

    logic [CNT_W:0] drop_sum;
    // A drop in the clear cycle restarts the count from this event.
    assign drop_sum = {1'b0, (clr_stats ? {CNT_W{1'b0}} : drop_cnt)} + (CNT_W+1)'(n);

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            drop_cnt <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
            overflow <= 1'b1;
        end else if (clr_stats) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_veer_trace_capture.sv
module tb_veer_trace_capture;
    import veer_trace_pkg::*;

    localparam int DEPTH = 64;
    localparam int CNT_W = 16;
    localparam int LW    = 7;
    localparam int CMAX  = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, capture_en, flush, clr_stats;
    logic [63:0]       insn, addr;
    logic [2:0]        valid, exc, intr;
    logic [4:0]        ecause;
    logic [31:0]       tval;
    logic [LW-1:0]     level;
    logic [CNT_W-1:0]  drop_cnt;
    logic              overflow;

    veer_trace_capture_if bus();

    veer_trace_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .capture_en              (capture_en),
        .flush                   (flush),
        .clr_stats               (clr_stats),
        .trace_rv_i_insn_ip      (insn),
        .trace_rv_i_address_ip   (addr),
        .trace_rv_i_valid_ip     (valid),
        .trace_rv_i_exception_ip (exc),
        .trace_rv_i_ecause_ip    (ecause),
        .trace_rv_i_interrupt_ip (intr),
        .trace_rv_i_tval_ip      (tval),
        .sink                    (bus),
        .level                   (level),
        .drop_cnt                (drop_cnt),
        .overflow                (overflow)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: queue of records in output order plus statistics.
    logic [102:0] q[$];
    int           m_drop;
    bit           m_ovf;

    function automatic logic [102:0] mk_rec(int lane);
        logic [102:0] r;
        r = {exc[lane], intr[lane], ecause, tval,
             (lane == 0) ? addr[31:0] : addr[63:32],
             (lane == 0) ? insn[31:0] : insn[63:32]};
        return r;
    endfunction

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int n;
        bit dropped;
        if (rst) begin
            q.delete();
            m_drop = 0;
            m_ovf  = 0;
            return;
        end
        n = (capture_en && !flush) ? (int'(valid[0]) + int'(valid[1])) : 0;
        dropped = (n > 0) && (n > DEPTH - q.size());
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (n > 0 && !dropped) begin
                if (valid[0]) q.push_back(mk_rec(0));
                if (valid[1]) q.push_back(mk_rec(1));
            end
        end
        if (dropped) begin
            m_drop = (clr_stats ? 0 : m_drop) + n;
            if (m_drop > CMAX) m_drop = CMAX;
            m_ovf = 1;
        end else if (clr_stats) begin
            m_drop = 0;
            m_ovf  = 0;
        end
    endtask

    task automatic check_all();
        check("valid", bus.out_valid, q.size() > 0);
        if (q.size() > 0) check("data", bus.out_data, q[0]);
        check("level", level, q.size());
        check("drop_cnt", drop_cnt, m_drop);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic cyc(bit do_chk);
        @(posedge clk);
        model_edge();
        #1;
        if (do_chk) check_all();
    endtask

    task automatic idle();
        valid = 3'b000; flush = 0; clr_stats = 0;
    endtask

    task automatic dual_rand();
        valid = 3'b011;
        insn  = {$urandom, $urandom};
        addr  = {$urandom, $urandom};
    endtask

    logic [102:0] held;
    bit           stalled;

    initial begin
        rst = 1; capture_en = 1; flush = 0; clr_stats = 0;
        insn = '0; addr = '0; valid = '0; exc = '0; intr = '0;
        ecause = '0; tval = '0; bus.out_ready = 1;
        q.delete(); m_drop = 0; m_ovf = 0;

        // Reset state
        cyc(1); cyc(1);
        check("rst_out_data", bus.out_data, 103'd0);
        check("rst_valid", bus.out_valid, 1'b0);
        rst = 0;

        // 1: dual-lane bundle, ordering and latency
        valid = 3'b011;
        insn  = {32'hBBBB0002, 32'hAAAA0001};
        addr  = {32'h104, 32'h100};
        cyc(1);
        check("t1_level_peak", level, 2);
        check("t1_addr0", bus.out_data[63:32], 32'h100);
        check("t1_insn0", bus.out_data[31:0], 32'hAAAA0001);
        idle();
        cyc(1);
        check("t1_addr1", bus.out_data[63:32], 32'h104);
        check("t1_insn1", bus.out_data[31:0], 32'hBBBB0002);
        cyc(1); cyc(1);
        check("t1_drop", drop_cnt, 0);

        // 2: fill to full, overflow, drop at level 63
        bus.out_ready = 0;
        for (int i = 0; i < 32; i++) begin dual_rand(); cyc(1); end
        check("t2_full", level, 64);
        dual_rand(); cyc(1);
        check("t2_full_hold", level, 64);
        check("t2_drop2", drop_cnt, 2);
        check("t2_ovf", overflow, 1'b1);
        idle(); bus.out_ready = 1; cyc(1);
        check("t2_level63", level, 63);
        bus.out_ready = 0; dual_rand(); cyc(1);
        check("t2_drop4", drop_cnt, 4);
        check("t2_level63b", level, 63);

        // 3: lane1-only record with exception
        idle(); flush = 1; cyc(1); flush = 0;
        valid = 3'b010; exc = 3'b010; ecause = 5'd2; tval = 32'hDEAD;
        insn  = {32'hBBBB0002, 32'hAAAA0001};
        addr  = {32'h104, 32'h100};
        cyc(1);
        check("t3_level", level, 1);
        check("t3_exc", bus.out_data[102], 1'b1);
        check("t3_intr", bus.out_data[101], 1'b0);
        check("t3_ecause", bus.out_data[100:96], 5'd2);
        check("t3_tval", bus.out_data[95:64], 32'hDEAD);
        check("t3_addr", bus.out_data[63:32], 32'h104);
        check("t3_insn", bus.out_data[31:0], 32'hBBBB0002);
        idle(); exc = 0; ecause = 0; tval = 0;

        // 4: flush with a full FIFO, input and pop in the same cycle
        flush = 1; cyc(1); flush = 0;
        for (int i = 0; i < 32; i++) begin dual_rand(); cyc(1); end
        check("t4_full", level, 64);
        dual_rand(); flush = 1; bus.out_ready = 1; cyc(1);
        check("t4_level0", level, 0);
        check("t4_valid0", bus.out_valid, 1'b0);
        check("t4_drop_kept", drop_cnt, 4);
        idle();

        // 5: saturation of drop_cnt, then clear
        bus.out_ready = 0;
        for (int i = 0; i < 32; i++) begin dual_rand(); cyc(1); end
        while (m_drop < 32'hFFFE) begin dual_rand(); cyc(0); end
        check_all();
        check("t5_fffe", drop_cnt, 16'hFFFE);
        dual_rand(); cyc(1);
        check("t5_sat1", drop_cnt, 16'hFFFF);
        dual_rand(); cyc(1);
        check("t5_sat2", drop_cnt, 16'hFFFF);
        idle(); clr_stats = 1; cyc(1);
        check("t5_clr_cnt", drop_cnt, 0);
        check("t5_clr_ovf", overflow, 1'b0);
        dual_rand(); clr_stats = 1; cyc(1);
        check("t5_clr_drop_cnt", drop_cnt, 2);
        check("t5_clr_drop_ovf", overflow, 1'b1);
        idle();
        capture_en = 0; dual_rand(); cyc(1);
        check("t5_capoff_drop", drop_cnt, 2);
        capture_en = 1; idle();

        // 6: random traffic with backpressure and a mid-run reset
        flush = 1; clr_stats = 1; cyc(1); idle();
        for (int i = 0; i < 1000; i++) begin
            valid      = 3'($urandom_range(0, 7));
            capture_en = ($urandom_range(0, 9) != 0);
            flush      = ($urandom_range(0, 49) == 0);
            clr_stats  = ($urandom_range(0, 99) == 0);
            exc        = 3'($urandom);
            intr       = 3'($urandom);
            ecause     = 5'($urandom);
            tval       = $urandom;
            insn       = {$urandom, $urandom};
            addr       = {$urandom, $urandom};
            bus.out_ready = $urandom_range(0, 1);
            rst        = (i == 500);
            stalled    = bus.out_valid && !bus.out_ready && !flush && !rst;
            held       = bus.out_data;
            cyc(1);
            check("t6_level_bound", level <= 7'd64, 1'b1);
            if (stalled) check("t6_stable", bus.out_data, held);
            if (i == 500) check("t6_rst_valid", bus.out_valid, 1'b0);
        end
        rst = 0; idle(); bus.out_ready = 1;
        for (int i = 0; i < 70; i++) cyc(1);
        check("t6_drained", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/veer_trace_capture.md
Name: veer_trace_capture

Overview:
- Sits directly downstream of the VeeR EH1 core's instruction trace port. Consumes the per-cycle retirement bundle: insn, address, valid, exception, ecause, interrupt and tval.
- Splits each bundle into one record per retired lane and buffers the records in a FIFO.
- Presents the records as a single valid/ready stream to a trace sink (debug UART dumper or trace RAM).
- Counts records lost to overflow so software can detect gaps.

Parameters:
- DEPTH, 64, FIFO entries; must be a power of 2 and at least 4.
- CNT_W, 16, width of the dropped-record counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- capture_en  in  1  when 0, all trace input is ignored (not counted as dropped)
- flush  in  1  single-cycle pulse; empties the FIFO
- clr_stats  in  1  single-cycle pulse; zeroes drop_cnt and overflow
- trace_rv_i_insn_ip  in  64  lane1 in [63:32], lane0 in [31:0]
- trace_rv_i_address_ip  in  64  lane1 in [63:32], lane0 in [31:0]
- trace_rv_i_valid_ip  in  3  [0] = lane0, [1] = lane1; [2] is ignored
- trace_rv_i_exception_ip  in  3  per-lane exception flag; [2] is ignored
- trace_rv_i_ecause_ip  in  5  shared exception cause
- trace_rv_i_interrupt_ip  in  3  per-lane interrupt flag; [2] is ignored
- trace_rv_i_tval_ip  in  32  shared tval
- out_valid  out  1  record available
- out_ready  in  1  sink accepts the record
- out_data  out  103  trace_rec_t: {exc, intr, ecause[4:0], tval[31:0], addr[31:0], insn[31:0]}
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- drop_cnt  out  CNT_W  saturating count of dropped records
- overflow  out  1  sticky; set on any drop

Behaviour:
- Reset (rst=1 at a clock edge): FIFO empty; out_valid=0; out_data=0; level=0; drop_cnt=0; overflow=0. Reset mid-stream discards all contents with no output.
- Per cycle, n = number of set lanes among valid[1:0], qualified by capture_en. n is 0, 1 or 2.
- Lane0 is pushed before lane1 and is output first.
- exc and intr come from the lane's own bit. ecause and tval are copied into every record of that cycle.
- Admission is atomic: if DEPTH - level >= n, all n records are written; otherwise none are written, drop_cnt += n (saturating at 2^CNT_W-1) and overflow is set.
- Free space is computed from level before this cycle's pop. A simultaneous pop does not make room in the same cycle.
- Latency: a record written at edge N can appear on out_valid after edge N (first-word latency is 1 cycle). FIFO is registered-output style. Full throughput: 2 writes and 1 read per cycle.
- Output handshake:
  - Pop occurs when out_valid && out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a pop, except on flush or rst.
- level update: level_next = level + writes - pop.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally. Full when level==DEPTH; empty when level==0.
- Flush: takes precedence over same-cycle writes and pop. Next cycle level=0 and out_valid=0. Input arriving in the flush cycle is discarded and not counted as dropped. drop_cnt and overflow are unaffected.
- clr_stats with a drop in the same cycle: drop_cnt=n and overflow=1 (the new event wins).
- capture_en=0: no writes and no drops; the output side keeps draining.

Decomposition:
- Package veer_trace_pkg holds:
  - typedef trace_rec_t (packed struct, 103 bits)
  - localparams REC_W=103 and LANES=2
  - function lane_count(valid[1:0])
- One sub-module, trace_fifo_2w1r: parameterized on DEPTH and record type; two write ports with an in-order enable; one registered read port; level output.
- The top level does lane extraction, admission and the statistics.

Test Plan:
1. Reset, then valid=3'b011, insn={32'hBBBB0002, 32'hAAAA0001}, addr={32'h104, 32'h100}, out_ready=1 -> records appear on consecutive cycles: addr 0x100/insn 0xAAAA0001, then addr 0x104/insn 0xBBBB0002; level peaks at 2; drop_cnt=0.
2. DEPTH=64, out_ready=0, dual-lane for 32 cycles -> level=64; a 33rd dual-lane cycle -> level stays 64, drop_cnt=2, overflow=1; with level=63, a dual-lane input -> both dropped, drop_cnt +2.
3. Lane1-only valid=3'b010 with exception=3'b010, ecause=5'd2, tval=32'hDEAD -> one record with exc=1, intr=0, ecause=2, tval=0xDEAD, lane1 addr/insn.
4. Full FIFO, flush together with a dual-lane input and out_ready=1 -> next cycle level=0, out_valid=0, drop_cnt unchanged.
5. Force drop_cnt to 0xFFFE, then two dual-lane overflow cycles -> drop_cnt=0xFFFF (saturated); clr_stats -> drop_cnt=0, overflow=0.
6. Random out_ready backpressure with 1000 random dual-lane bundles -> scoreboard order matches; out_data is stable while stalled; level never exceeds 64; rst asserted at cycle 500 -> out_valid=0 next cycle.
